// File: rtl/uart_dce_pkg.sv
// Shared types and constants for the multi-port UART DCE echo endpoint.
// Parity support is selected with the UART_DCE_PARITY_EN macro.
package uart_dce_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int frame_bits();
`ifdef UART_DCE_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

endpackage

// File: rtl/uart_dce_port.sv
// One UART DCE echo channel: synchronisers, RX deserialiser, byte FIFO,
// RTS/CTS-gated TX serialiser and sticky status. Parity via UART_DCE_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle; RX waits for a falling edge, TX waits for data and rts
// START  | RX: half-bit check of the start bit; TX: driving the start bit
// DATA   | eight data bits, LSB first, one per bit period
// PARITY | even parity bit (only with UART_DCE_PARITY_EN)
// STOP   | RX: stop-bit sample; TX: driving the stop bit
module uart_dce_port
  import uart_dce_pkg::*;
#(
  parameter int DIVISOR    = 87,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rts_i,
  input  logic txd_i,
  output logic cts_o,
  output logic rxd_o,
  output logic overflow_o,
  output logic frame_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DIVISOR + 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   MARGIN_C  = (AW + 1)'(CTS_MARGIN);

  logic [1:0] txd_sync_q, rts_sync_q;
  logic       txd_prev_q;
  logic       rx_line, rts_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txd_sync_q <= 2'b11;
      rts_sync_q <= 2'b00;
      txd_prev_q <= 1'b1;
    end else begin
      txd_sync_q <= {txd_sync_q[0], txd_i};
      rts_sync_q <= {rts_sync_q[0], rts_i};
      txd_prev_q <= txd_sync_q[1];
    end
  end

  assign rx_line = txd_sync_q[1];
  assign rts_ok  = rts_sync_q[1];

  // RX deserialiser
  uart_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_tc, push, ferr_set;
`ifdef UART_DCE_PARITY_EN
  logic              rx_perr_q, rx_perr_d;
`endif

  assign rx_tc = (rx_cnt_q == '0);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    push       = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_DCE_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    unique case (rx_state_q)
      IDLE: begin
        if (txd_prev_q && !rx_line) begin
          rx_state_d = START;
          rx_cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!rx_tc) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else if (rx_line) begin
          rx_state_d = IDLE;
        end else begin
          rx_state_d = DATA;
          rx_cnt_d   = BIT_LOAD;
          rx_bit_d   = 3'd0;
`ifdef UART_DCE_PARITY_EN
          rx_perr_d  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (!rx_tc) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LOAD;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
`ifdef UART_DCE_PARITY_EN
            rx_state_d = PARITY;
`else
            rx_state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_DCE_PARITY_EN
      PARITY: begin
        if (!rx_tc) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
          rx_perr_d  = (rx_line != ^rx_shift_q);
          rx_cnt_d   = BIT_LOAD;
          rx_state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!rx_tc) begin
          rx_cnt_d = rx_cnt_q - CW'(1);
        end else begin
          rx_state_d = IDLE;
`ifdef UART_DCE_PARITY_EN
          if (rx_line && !rx_perr_q) push = 1'b1;
`else
          if (rx_line) push = 1'b1;
`endif
          else ferr_set = 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
`ifdef UART_DCE_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
`ifdef UART_DCE_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  // Byte FIFO; a push into a full FIFO is still accepted if a pop frees a slot
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          pop, push_ok, ovf_set, full, empty;
  logic          cts_q, ovf_q, ferr_q;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      cts_q   <= (DEPTH_C - count_d) > MARGIN_C;
      ovf_q   <= ovf_q | ovf_set;
      ferr_q  <= ferr_q | ferr_set;
    end
  end

  // TX serialiser
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          rxd_q, rxd_d, tx_tc;
`ifdef UART_DCE_PARITY_EN
  logic          tx_par_q, tx_par_d;
`endif

  assign tx_tc = (tx_cnt_q == '0);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    rxd_d      = rxd_q;
    pop        = 1'b0;
`ifdef UART_DCE_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    unique case (tx_state_q)
      IDLE: begin
        rxd_d = 1'b1;
        if (!empty && rts_ok) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
`ifdef UART_DCE_PARITY_EN
          tx_par_d   = ^mem_q[rd_ptr_q];
`endif
          rxd_d      = 1'b0;
          tx_cnt_d   = BIT_LOAD;
          tx_state_d = START;
        end
      end
      START: begin
        if (!tx_tc) begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
          rxd_d      = tx_shift_q[0];
          tx_bit_d   = 3'd0;
          tx_cnt_d   = BIT_LOAD;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        if (!tx_tc) begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
          tx_cnt_d = BIT_LOAD;
          if (tx_bit_q == 3'd7) begin
`ifdef UART_DCE_PARITY_EN
            rxd_d      = tx_par_q;
            tx_state_d = PARITY;
`else
            rxd_d      = 1'b1;
            tx_state_d = STOP;
`endif
          end else begin
            rxd_d      = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
`ifdef UART_DCE_PARITY_EN
      PARITY: begin
        if (!tx_tc) begin
          tx_cnt_d = tx_cnt_q - CW'(1);
        end else begin
          rxd_d      = 1'b1;
          tx_cnt_d   = BIT_LOAD;
          tx_state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!tx_tc) tx_cnt_d = tx_cnt_q - CW'(1);
        else        tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rxd_q      <= 1'b1;
`ifdef UART_DCE_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rxd_q      <= rxd_d;
`ifdef UART_DCE_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign cts_o       = cts_q;
  assign rxd_o       = rxd_q;
  assign overflow_o  = ovf_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_dce_echo_mp.sv
// Multi-port UART DCE echo endpoint: NUM_PORTS independent echo channels plus
// per-port divisor export. Even parity is enabled with UART_DCE_PARITY_EN.
module uart_dce_echo_mp
  import uart_dce_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int DIVISOR    = 87,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_MARGIN = 2
) (
  input  logic                    clock10M,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    rts,
  output logic [NUM_PORTS-1:0]    cts,
  input  logic [NUM_PORTS-1:0]    txd,
  output logic [NUM_PORTS-1:0]    rxd,
  output logic [32*NUM_PORTS-1:0] dbr,
  output logic [NUM_PORTS-1:0]    overflow,
  output logic [NUM_PORTS-1:0]    frame_err
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    uart_dce_port #(
      .DIVISOR   (DIVISOR),
      .FIFO_DEPTH(FIFO_DEPTH),
      .CTS_MARGIN(CTS_MARGIN)
    ) u_port (
      .clk_i      (clock10M),
      .rst_i      (reset),
      .rts_i      (rts[p]),
      .txd_i      (txd[p]),
      .cts_o      (cts[p]),
      .rxd_o      (rxd[p]),
      .overflow_o (overflow[p]),
      .frame_err_o(frame_err[p])
    );

    // Constant even through reset so the transactor can lock before release
    assign dbr[32*p +: 32] = 32'(DIVISOR);
  end

endmodule

// File: tb/tb_uart_dce_echo_mp.sv
// Self-checking bench for uart_dce_echo_mp: random bytes through a queue-based
// echo model, flow control, overflow, glitch/framing and reset-mid-echo cases.
module tb_uart_dce_echo_mp;
  import uart_dce_pkg::*;

  localparam int NP     = 2;
  localparam int DIV    = 87;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   rts;
  logic [NP-1:0]   cts;
  logic [NP-1:0]   txd;
  logic [NP-1:0]   rxd;
  logic [32*NP-1:0] dbr;
  logic [NP-1:0]   overflow;
  logic [NP-1:0]   frame_err;
  logic            txd_drv [NP];

  logic [7:0] got_q [NP][$];
  logic [7:0] exp_q [NP][$];
  int n_cmp = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_drv
    assign txd[g] = txd_drv[g];
  end

  uart_dce_echo_mp #(
    .NUM_PORTS (NP),
    .DIVISOR   (DIV),
    .FIFO_DEPTH(DEPTH),
    .CTS_MARGIN(MARGIN)
  ) dut (
    .clock10M (clk),
    .reset    (reset),
    .rts      (rts),
    .cts      (cts),
    .txd      (txd),
    .rxd      (rxd),
    .dbr      (dbr),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // DTE-side serial driver; stop_b=0 produces a framing error
  task automatic send_byte(input int p, input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    txd_drv[p] = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txd_drv[p] = b[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_DCE_PARITY_EN
    txd_drv[p] = ^b;
    repeat (DIV) @(negedge clk);
`endif
    txd_drv[p] = stop_b;
    repeat (DIV) @(negedge clk);
    txd_drv[p] = 1'b1;
  endtask

  // DTE-side receivers: decode whatever appears on rxd into got_q
  for (genvar g = 0; g < NP; g++) begin : g_mon
    initial begin
      logic [7:0] b;
      forever begin
        @(negedge clk);
        if (rxd[g] === 1'b0 && reset === 1'b0) begin
          repeat (DIV / 2) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = rxd[g];
          end
`ifdef UART_DCE_PARITY_EN
          repeat (DIV) @(negedge clk);
`endif
          repeat (DIV) @(negedge clk);
          got_q[g].push_back(b);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) until every port has echoed what the model expects, then compare
  task automatic drain_and_compare(input string tag);
    int bound;
    int n;
    bound = (exp_q[0].size() + exp_q[1].size() + 2) * frame_bits() * DIV + 200;
    n = 0;
    while ((got_q[0].size() < exp_q[0].size() || got_q[1].size() < exp_q[1].size()) && n < bound) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * DIV) @(negedge clk);
    check_val({tag, "_drain_in_time"}, 32'(n < bound), 32'd1);
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("%s_count_p%0d", tag, p), 32'(got_q[p].size()), 32'(exp_q[p].size()));
      for (int i = 0; i < exp_q[p].size(); i++) begin
        if (i < got_q[p].size())
          check_val($sformatf("%s_byte_p%0d_%0d", tag, p, i), 32'(got_q[p][i]), 32'(exp_q[p][i]));
      end
      got_q[p].delete();
      exp_q[p].delete();
    end
  endtask

  // Fill a port with rts held low; the model keeps the first DEPTH bytes
  task automatic fill_port(input int p, input int k);
    int stored;
    logic [7:0] b;
    stored = 0;
    for (int i = 1; i <= k; i++) begin
      b = 8'($urandom);
      send_byte(p, b, 1'b1);
      if (stored < DEPTH) begin
        exp_q[p].push_back(b);
        stored++;
      end
      check_val($sformatf("cts_fill_p%0d_%0d", p, i), 32'(cts[p]), 32'((DEPTH - stored) > MARGIN));
      check_val($sformatf("ovf_fill_p%0d_%0d", p, i), 32'(overflow[p]), 32'(i > DEPTH));
    end
  endtask

  initial begin
    int n;
    logic [7:0] b;
    reset = 1'b1;
    rts   = '0;
    for (int p = 0; p < NP; p++) txd_drv[p] = 1'b1;
    repeat (3) @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("rst_rxd_p%0d", p), 32'(rxd[p]), 32'd1);
      check_val($sformatf("rst_cts_p%0d", p), 32'(cts[p]), 32'd0);
      check_val($sformatf("rst_ovf_p%0d", p), 32'(overflow[p]), 32'd0);
      check_val($sformatf("rst_ferr_p%0d", p), 32'(frame_err[p]), 32'd0);
      check_val($sformatf("rst_dbr_p%0d", p), dbr[32*p +: 32], 32'(DIV));
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("cts_after_reset_p0", 32'(cts[0]), 32'd1);
    rts = '1;

    // Single byte and port isolation
    exp_q[0].push_back(8'hA5);
    send_byte(0, 8'hA5, 1'b1);
    drain_and_compare("single");
    check_val("single_ferr_p0", 32'(frame_err[0]), 32'd0);
    exp_q[0].push_back(8'h00);
    exp_q[1].push_back(8'hFF);
    fork
      send_byte(0, 8'h00, 1'b1);
      send_byte(1, 8'hFF, 1'b1);
    join
    drain_and_compare("isolate");
    check_val("dbr_p0", dbr[31:0], 32'(DIV));
    check_val("dbr_p1", dbr[63:32], 32'(DIV));

    // Random concurrent traffic with rts open
    fork
      for (int i = 0; i < 4; i++) begin
        logic [7:0] r0;
        r0 = 8'($urandom);
        exp_q[0].push_back(r0);
        send_byte(0, r0, 1'b1);
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
        logic [7:0] r1;
        r1 = 8'($urandom);
        exp_q[1].push_back(r1);
        send_byte(1, r1, 1'b1);
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
    join
    drain_and_compare("random");

    // Flow control on port 0 and overflow on port 1, both with rts low
    rts = '0;
    repeat (4) @(negedge clk);
    fork
      fill_port(0, 14);
      fill_port(1, 17);
    join
    rts = '1;
    repeat (6) @(negedge clk);
    check_val("cts_after_pop_p0", 32'(cts[0]), 32'((DEPTH - 13) > MARGIN));
    check_val("cts_after_pop_p1", 32'(cts[1]), 32'((DEPTH - 15) > MARGIN));
    drain_and_compare("flow");
    check_val("flow_ovf_p0", 32'(overflow[0]), 32'd0);
    check_val("flow_ovf_p1", 32'(overflow[1]), 32'd1);
    check_val("flow_cts_p1", 32'(cts[1]), 32'd1);
    check_val("flow_ferr_p1", 32'(frame_err[1]), 32'd0);
    do_reset(2);
    @(negedge clk);
    check_val("ovf_cleared_p1", 32'(overflow[1]), 32'd0);
    rts = '1;

    // Glitch then bad stop bit on port 0
    @(negedge clk);
    txd_drv[0] = 1'b0;
    repeat (20) @(negedge clk);
    txd_drv[0] = 1'b1;
    repeat (frame_bits() * DIV) @(negedge clk);
    check_val("glitch_ferr", 32'(frame_err[0]), 32'd0);
    check_val("glitch_noecho", 32'(got_q[0].size()), 32'd0);
    b = 8'($urandom);
    send_byte(0, b, 1'b0);
    repeat ((frame_bits() + 2) * DIV) @(negedge clk);
    check_val("badstop_ferr", 32'(frame_err[0]), 32'd1);
    check_val("badstop_noecho", 32'(got_q[0].size()), 32'd0);
    check_val("badstop_ferr_p1", 32'(frame_err[1]), 32'd0);

    // Reset during TX bit 4 with more bytes buffered behind it
    rts = '0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) send_byte(0, 8'($urandom), 1'b1);
    rts = '1;
    n = 0;
    while (rxd[0] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("echo_start_seen", 32'(n < 50), 32'd1);
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midreset_rxd", 32'(rxd[0]), 32'd1);
    check_val("midreset_cts", 32'(cts[0]), 32'd0);
    repeat (3) @(negedge clk);
    check_val("midreset_cts_hold", 32'(cts[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("midreset_cts_release", 32'(cts[0]), 32'd1);
    repeat (12 * DIV) @(negedge clk);
    got_q[0].delete();
    repeat (12 * DIV) @(negedge clk);
    check_val("midreset_fifo_empty", 32'(got_q[0].size()), 32'd0);
    check_val("midreset_rxd_idle", 32'(rxd[0]), 32'd1);
    check_val("midreset_ferr", 32'(frame_err[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
